bitserial_conv_mac: RTL

// - Bit-serial CIM convolution MAC, parametrised successor of the fixed 32-input x 4-bit engine.
// - N_IN parallel 1-bit activation lanes per cycle, sent LSB-first over A_BITS cycles.
// - Each lane is multiplied by a runtime-loadable weight for each of N_OCH output channels.
// - Adds: unsigned/signed activation mode and an out_valid/out_ready handshake with backpressure.
// - Sits between the IFM bit-slicer and the OFM writeback buffer.

---
 rtl/bitserial_conv_mac.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bitserial_conv_mac.sv
// Bit-serial CIM convolution MAC: N_IN 1-bit activation lanes per beat, LSB-first over
// A_BITS beats, multiplied by runtime-loadable weights for N_OCH output channels.
module bitserial_conv_mac #(
    parameter int N_IN   = 32,
    parameter int W_BITS = 4,
    parameter int A_BITS = 4,
    parameter int N_OCH  = 2,
    parameter int OUT_W  = W_BITS + A_BITS + $clog2(N_IN) + 1
) (
    input  logic                     clk_gate_IN1,
    input  logic                     rst_n,
    input  logic                     w_we,
    input  logic [$clog2(N_OCH)-1:0] w_och,
    input  logic [$clog2(N_IN)-1:0]  w_idx,
    input  logic [W_BITS-1:0]        w_data,
    output logic                     w_err,
    input  logic                     signed_act,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OCH*OUT_W-1:0]   out_ofm
);

    localparam int KW  = (A_BITS > 1) ? $clog2(A_BITS) : 1;
    localparam int P_W = W_BITS + $clog2(N_IN + 1);
    localparam logic [KW-1:0] K_LAST = KW'(A_BITS - 1);

    logic [W_BITS-1:0] w_mem [N_OCH][N_IN];

    logic            adv;
    logic            beat;
    logic            w_ok;
    logic [KW-1:0]   k;
    logic            sign_hold;

    logic            s1_valid;
    logic            s1_last;
    logic            s1_signed;
    logic [KW-1:0]   s1_k;
    logic [P_W-1:0]  s1_p   [N_OCH];
    logic [P_W-1:0]  p_next [N_OCH];

    logic             s2_last;
    logic [OUT_W-1:0] acc      [N_OCH];
    logic [OUT_W-1:0] acc_next [N_OCH];
    logic [OUT_W-1:0] term     [N_OCH];
    logic [OUT_W-1:0] base     [N_OCH];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign beat     = in_valid && adv;

    // A write is only safe when no beat of any word sits anywhere in the pipeline.
    assign w_ok = w_we && !beat && (k == '0) && !s1_valid && !s2_last &&
                  (32'(w_och) < 32'(N_OCH)) && (32'(w_idx) < 32'(N_IN));

    always_ff @(posedge clk_gate_IN1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < N_OCH; c++)
                for (int unsigned i = 0; i < N_IN; i++)
                    w_mem[c][i] <= '0;
            w_err <= 1'b0;
        end else begin
            if (w_ok)
                w_mem[w_och][w_idx] <= w_data;
            w_err <= w_we && !w_ok;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_OCH; c++) begin
            p_next[c] = '0;
            for (int unsigned i = 0; i < N_IN; i++)
                if (in_bits[i])
                    p_next[c] = p_next[c] + P_W'(w_mem[c][i]);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_OCH; c++) begin
            term[c]     = OUT_W'(s1_p[c]) << s1_k;
            base[c]     = (s1_k == '0) ? '0 : acc[c];
            acc_next[c] = (s1_signed && s1_last) ? base[c] - term[c] : base[c] + term[c];
        end
    end

    always_ff @(posedge clk_gate_IN1 or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            sign_hold <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            s1_k      <= '0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_ofm   <= '0;
            for (int unsigned c = 0; c < N_OCH; c++) begin
                s1_p[c] <= '0;
                acc[c]  <= '0;
            end
        end else if (adv) begin
            s1_valid <= beat;
            if (beat) begin
                k         <= (k == K_LAST) ? '0 : k + 1'b1;
                s1_k      <= k;
                s1_last   <= (k == K_LAST);
                s1_signed <= (k == '0) ? signed_act : sign_hold;
                if (k == '0)
                    sign_hold <= signed_act;
                for (int unsigned c = 0; c < N_OCH; c++)
                    s1_p[c] <= p_next[c];
            end
            if (s1_valid)
                for (int unsigned c = 0; c < N_OCH; c++)
                    acc[c] <= acc_next[c];
            s2_last <= s1_valid && s1_last;
            // adv with out_valid set implies out_ready, so clearing here is an accept.
            out_valid <= s2_last;
            if (s2_last)
                for (int unsigned c = 0; c < N_OCH; c++)
                    out_ofm[c*OUT_W +: OUT_W] <= acc[c];
        end
    end

endmodule
